// File: rtl/serial_adder_n.sv
// rtl/serial_adder_n.sv - bit-serial adder/subtractor with start/busy/done handshake
module serial_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_ps;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             w_bit;
  logic             w_cy;
  logic             w_last;
  logic             w_load;
  logic [WIDTH-1:0] w_ps_next;

  // Single full-adder cell working on the operand LSBs and the carry FF.
  assign w_bit  = r_a[0] ^ r_b[0] ^ r_c;
  assign w_cy   = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // New result bit enters at the MSB; for a 1-bit adder it is the whole result.
  generate
    if (WIDTH == 1) begin : g_ps_w1
      assign w_ps_next = w_bit;
    end else begin : g_ps_wn
      assign w_ps_next = {w_bit, r_ps[WIDTH-1:1]};
    end
  endgenerate

  // Next-state and handshake decode; start is only honoured outside RUN.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Datapath: capture operands on accepted start, shift one bit per RUN cycle.
  // Subtract is done as A + ~B + ~Cin, so Sub need not be kept after capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_ps  <= '0;
      r_cnt <= '0;
      r_c   <= 1'b0;
    end else if (w_load) begin
      r_a   <= A;
      r_b   <= Sub ? ~B : B;
      r_c   <= Sub ? ~Cin : Cin;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_ps  <= w_ps_next;
      r_c   <= w_cy;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Visible results update only on the edge entering DONE; overflow is the
  // carry into the MSB cell XOR the carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Sum  <= '0;
      Cout <= 1'b0;
      Ovf  <= 1'b0;
    end else if (r_state == S_RUN && w_last) begin
      Sum  <= w_ps_next;
      Cout <= w_cy;
      Ovf  <= r_c ^ w_cy;
    end
  end

endmodule

// File: tb/tb_serial_adder_n.sv
// tb/tb_serial_adder_n.sv - directed and exhaustive checks of serial_adder_n
module tb_serial_adder_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start8 = 0, Sub8 = 0, Cin8 = 0;
  logic [7:0] A8 = 0, B8 = 0;
  logic       busy8, done8, Cout8, Ovf8;
  logic [7:0] Sum8;

  logic       start4 = 0, Sub4 = 0, Cin4 = 0;
  logic [3:0] A4 = 0, B4 = 0;
  logic       busy4, done4, Cout4, Ovf4;
  logic [3:0] Sum4;

  logic       start1 = 0, Sub1 = 0, Cin1 = 0;
  logic [0:0] A1 = 0, B1 = 0;
  logic       busy1, done1, Cout1, Ovf1;
  logic [0:0] Sum1;

  serial_adder_n #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start8), .Sub(Sub8), .A(A8), .B(B8), .Cin(Cin8),
    .busy(busy8), .done(done8), .Sum(Sum8), .Cout(Cout8), .Ovf(Ovf8)
  );
  serial_adder_n #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .start(start4), .Sub(Sub4), .A(A4), .B(B4), .Cin(Cin4),
    .busy(busy4), .done(done4), .Sum(Sum4), .Cout(Cout4), .Ovf(Ovf4)
  );
  serial_adder_n #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .start(start1), .Sub(Sub1), .A(A1), .B(B1), .Cin(Cin1),
    .busy(busy1), .done(done1), .Sum(Sum1), .Cout(Cout1), .Ovf(Ovf1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic from integer and signed-range reasoning.
  function automatic void ref_op(input int w, input logic s, input int a, input int b,
                                 input logic c, output int sum, output logic co,
                                 output logic ov);
    int m, sa, sb, r, sr;
    m  = 1 << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (!s) begin
      r  = a + b + int'(c);
      co = (r >= m);
      sr = sa + sb + int'(c);
    end else begin
      r  = a - b - int'(c);
      co = (r >= 0);
      sr = sa - sb - int'(c);
      if (r < 0) r = r + m;
    end
    sum = r % m;
    ov  = (sr < -(m / 2)) || (sr >= m / 2);
  endfunction

  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic c,
                     output int lat, output int nbusy);
    Sub8 = s; A8 = a; B8 = b; Cin8 = c; start8 = 1'b1;
    lat = 0; nbusy = 0;
    do begin
      @(negedge clk);
      lat++;
      start8 = 1'b0;
      if (busy8) nbusy++;
    end while (!done8 && lat < 40);
  endtask

  task automatic op4(input logic s, input logic [3:0] a, input logic [3:0] b, input logic c,
                     output int lat);
    Sub4 = s; A4 = a; B4 = b; Cin4 = c; start4 = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start4 = 1'b0;
    end while (!done4 && lat < 40);
  endtask

  task automatic op1(input logic s, input logic a, input logic b, input logic c,
                     output int lat);
    Sub1 = s; A1 = a; B1 = b; Cin1 = c; start1 = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start1 = 1'b0;
    end while (!done1 && lat < 40);
  endtask

  initial begin
    int lat, nb, ndone, lastdone, rsum;
    logic [7:0] exp_sum, held;
    logic rco, rov;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_sum", Sum8, 0);
    check("rst_cout", Cout8, 0);
    check("rst_ovf", Ovf8, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: basic add, latency and busy length
    op8(0, 8'h0F, 8'h01, 0, lat, nb);
    check("t1_lat", lat, 9);
    check("t1_busy_cycles", nb, 8);
    check("t1_busy_at_done", busy8, 0);
    check("t1_sum", Sum8, 8'h10);
    check("t1_cout", Cout8, 0);
    check("t1_ovf", Ovf8, 0);
    @(negedge clk);
    check("t1_done_pulse", done8, 0);

    // 2: carry out and signed overflow on add
    op8(0, 8'hFF, 8'h01, 1, lat, nb);
    check("t2a_sum", Sum8, 8'h01);
    check("t2a_cout", Cout8, 1);
    check("t2a_ovf", Ovf8, 0);
    op8(0, 8'h7F, 8'h01, 0, lat, nb);
    check("t2b_sum", Sum8, 8'h80);
    check("t2b_cout", Cout8, 0);
    check("t2b_ovf", Ovf8, 1);

    // 3: subtract with borrow and signed overflow (back-to-back from DONE)
    op8(1, 8'h05, 8'h07, 0, lat, nb);
    check("t3a_sum", Sum8, 8'hFE);
    check("t3a_cout", Cout8, 0);
    check("t3a_ovf", Ovf8, 0);
    op8(1, 8'h80, 8'h01, 0, lat, nb);
    check("t3b_lat", lat, 9);
    check("t3b_sum", Sum8, 8'h7F);
    check("t3b_cout", Cout8, 1);
    check("t3b_ovf", Ovf8, 1);
    @(negedge clk);

    // 4: start held high, operands changing every cycle
    Sub8 = 0; Cin8 = 0; A8 = 8'h11; B8 = 8'h22; start8 = 1'b1;
    exp_sum = 8'h33; held = 8'h7F;
    ndone = 0; lastdone = 0;
    for (int cyc = 1; cyc <= 60 && ndone < 4; cyc++) begin
      @(negedge clk);
      if (done8) begin
        check("t4_sum", Sum8, exp_sum);
        if (ndone > 0) check("t4_gap", cyc - lastdone, 9);
        held = exp_sum; lastdone = cyc; ndone++;
        A8 = A8 + 8'h07; B8 = B8 + 8'h19;
        exp_sum = A8 + B8;
      end else begin
        check("t4_hold", Sum8, held);
        A8 = A8 + 8'h13; B8 = B8 ^ 8'h5A;
      end
    end
    check("t4_ndone", ndone, 4);
    start8 = 1'b0;
    repeat (12) @(negedge clk);

    // 5: asynchronous reset mid-operation
    op8(0, 8'hAA, 8'h11, 0, lat, nb);
    check("t5_pre_sum", Sum8, 8'hBB);
    Sub8 = 0; A8 = 8'h55; B8 = 8'h22; Cin8 = 0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_busy_before", busy8, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_busy", busy8, 0);
    check("t5_rst_done", done8, 0);
    check("t5_rst_sum", Sum8, 0);
    check("t5_rst_cout", Cout8, 0);
    check("t5_rst_ovf", Ovf8, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done8 || busy8) ndone++;
    end
    check("t5_no_done_after_rst", ndone, 0);
    op8(0, 8'h55, 8'h22, 0, lat, nb);
    check("t5_lat", lat, 9);
    check("t5_sum", Sum8, 8'h77);
    @(negedge clk);

    // 6a: exhaustive WIDTH=4
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 2; c++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++) begin
            op4(s[0], a[3:0], b[3:0], c[0], lat);
            ref_op(4, s[0], a, b, c[0], rsum, rco, rov);
            check("w4_lat", lat, 5);
            check("w4_sum", Sum4, rsum);
            check("w4_cout", Cout4, rco);
            check("w4_ovf", Ovf4, rov);
          end
    @(negedge clk);

    // 6b: WIDTH=1 full-adder truth table, then subtract mode
    for (int s = 0; s < 2; s++)
      for (int v = 0; v < 8; v++) begin
        op1(s[0], v[2], v[1], v[0], lat);
        ref_op(1, s[0], int'(v[2]), int'(v[1]), v[0], rsum, rco, rov);
        check("w1_lat", lat, 2);
        check("w1_sum", Sum1, rsum);
        check("w1_cout", Cout1, rco);
        check("w1_ovf", Ovf1, rov);
      end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
